// File: rtl/window_flasher_if.sv
// Bus between window_flasher and its environment: continuation handshake,
// window description, pixel-memory read port and VGA plot outputs.
interface window_flasher_if #(
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int COLOR_SIZE = 3,
  parameter int ADDR_BITS  = 15
);
  logic                  in_cont_signal;
  logic                  next_fin_signal;
  logic [X_BITS-1:0]     win_x0;
  logic [Y_BITS-1:0]     win_y0;
  logic [X_BITS:0]       win_w;
  logic [Y_BITS:0]       win_h;
  logic [COLOR_SIZE-1:0] bg_colour;
  logic [ADDR_BITS-1:0]  read_addr;
  logic [COLOR_SIZE-1:0] read_data;
  logic [X_BITS-1:0]     x_co;
  logic [Y_BITS-1:0]     y_co;
  logic [COLOR_SIZE-1:0] colour;
  logic                  plot;
  logic                  out_cont_signal;
  logic                  busy;

  modport master (
    input  in_cont_signal, next_fin_signal, win_x0, win_y0, win_w, win_h,
           bg_colour, read_data,
    output read_addr, x_co, y_co, colour, plot, out_cont_signal, busy
  );

  modport slave (
    output in_cont_signal, next_fin_signal, win_x0, win_y0, win_w, win_h,
           bg_colour, read_data,
    input  read_addr, x_co, y_co, colour, plot, out_cont_signal, busy
  );
endinterface

// File: rtl/window_flasher.sv
// Scans a clipped framebuffer window, reads each pixel and emits one plot per pixel.
// Optional FLASH_SKIP_BG_EN: pixels whose colour equals bg_colour are not plotted.
module window_flasher #(
  parameter int SCR_WIDTH    = 160,
  parameter int SCR_HEIGHT   = 120,
  parameter int COLOR_SIZE   = 3,
  parameter int READ_LATENCY = 1,
  parameter int X_BITS       = 8,
  parameter int Y_BITS       = 7,
  parameter int ADDR_BITS    = 15
) (
  input  logic             Clck,
  input  logic             Reset,
  window_flasher_if.master bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] PLOT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int XW      = X_BITS + 2;
  localparam int YW      = Y_BITS + 2;
  localparam int WC_BITS = $clog2(READ_LATENCY + 2);

  localparam logic [XW-1:0]        SW_X = XW'(SCR_WIDTH);
  localparam logic [YW-1:0]        SH_Y = YW'(SCR_HEIGHT);
  localparam logic [ADDR_BITS-1:0] SW_A = ADDR_BITS'(SCR_WIDTH);
  localparam logic [WC_BITS-1:0]   WLST = WC_BITS'(READ_LATENCY);

  logic [2:0]           state;
  logic [X_BITS-1:0]    x, x0, xe;
  logic [Y_BITS-1:0]    y, ye;
  logic [WC_BITS-1:0]   wcnt;

  logic [XW-1:0]        x_sum;
  logic [YW-1:0]        y_sum;
  logic [X_BITS-1:0]    xe_clip;
  logic [Y_BITS-1:0]    ye_clip;
  logic                 empty, last_col, last_row;
  logic [ADDR_BITS-1:0] addr_n;

  // Sums are two bits wider than the coordinates so x0+w can never wrap.
  assign x_sum   = XW'(bus.win_x0) + XW'(bus.win_w);
  assign y_sum   = YW'(bus.win_y0) + YW'(bus.win_h);
  assign xe_clip = (x_sum > SW_X) ? X_BITS'(SCR_WIDTH)  : x_sum[X_BITS-1:0];
  assign ye_clip = (y_sum > SH_Y) ? Y_BITS'(SCR_HEIGHT) : y_sum[Y_BITS-1:0];
  assign empty   = (bus.win_w == '0) || (bus.win_h == '0) ||
                   (XW'(bus.win_x0) >= SW_X) || (YW'(bus.win_y0) >= SH_Y);

  assign last_col = (x == xe - X_BITS'(1));
  assign last_row = (y == ye - Y_BITS'(1));
  assign addr_n   = ADDR_BITS'(y) * SW_A + ADDR_BITS'(x);

  assign bus.out_cont_signal = (state == DONE);
  assign bus.busy            = (state != IDLE);

`ifdef FLASH_SKIP_BG_EN
  assign bus.plot = (state == PLOT) && (bus.colour != bus.bg_colour);
`else
  assign bus.plot = (state == PLOT);
  logic unused_bg;
  assign unused_bg = ^bus.bg_colour;
`endif

  always_ff @(posedge Clck) begin
    if (!Reset) begin
      state         <= IDLE;
      bus.read_addr <= '0;
      bus.x_co      <= '0;
      bus.y_co      <= '0;
      bus.colour    <= '0;
      x             <= '0;
      y             <= '0;
      x0            <= '0;
      xe            <= '0;
      ye            <= '0;
      wcnt          <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_cont_signal) begin
          x0    <= bus.win_x0;
          x     <= bus.win_x0;
          y     <= bus.win_y0;
          xe    <= xe_clip;
          ye    <= ye_clip;
          state <= empty ? DONE : ISSUE;
        end
        // Pause point: a dropped in_cont_signal holds here between pixels.
        ISSUE: if (bus.in_cont_signal) begin
          bus.read_addr <= addr_n;
          wcnt          <= '0;
          state         <= WAIT;
        end
        WAIT: if (wcnt == WLST) begin
          bus.colour <= bus.read_data;
          bus.x_co   <= x;
          bus.y_co   <= y;
          state      <= PLOT;
        end else begin
          wcnt <= wcnt + WC_BITS'(1);
        end
        PLOT: if (last_col) begin
          if (last_row) begin
            state <= DONE;
          end else begin
            x     <= x0;
            y     <= y + Y_BITS'(1);
            state <= ISSUE;
          end
        end else begin
          x     <= x + X_BITS'(1);
          state <= ISSUE;
        end
        DONE: if (bus.next_fin_signal) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_window_flasher.sv
// Directed bench for window_flasher: three instances (full screen, general, READ_LATENCY=3).
module tb_window_flasher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  window_flasher_if #(.X_BITS(8), .Y_BITS(7), .COLOR_SIZE(3), .ADDR_BITS(15)) ia ();
  window_flasher_if #(.X_BITS(8), .Y_BITS(7), .COLOR_SIZE(3), .ADDR_BITS(15)) ib ();
  window_flasher_if #(.X_BITS(8), .Y_BITS(7), .COLOR_SIZE(3), .ADDR_BITS(15)) ic ();

  window_flasher dut_a (.Clck(clk), .Reset(rst_n), .bus(ia.master));
  window_flasher dut_b (.Clck(clk), .Reset(rst_b), .bus(ib.master));
  window_flasher #(.READ_LATENCY(3)) dut_c (.Clck(clk), .Reset(rst_n), .bus(ic.master));

  // Pixel memories: A = addr[2:0] (1 cycle), B = table (1 cycle), C = 3-stage pipe.
  logic [2:0] mem_b [0:19199];
  logic [2:0] pc [0:2];
  always @(posedge clk) ia.read_data <= ia.read_addr[2:0];
  always @(posedge clk) ib.read_data <= mem_b[ib.read_addr];
  always @(posedge clk) begin
    pc[0] <= ic.read_addr[2:0] ^ ic.read_addr[6:4];
    pc[1] <= pc[0];
    pc[2] <= pc[1];
  end
  assign ic.read_data = pc[2];

  typedef struct packed {
    logic [31:0] t;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
  } pl_t;

  pl_t qb[$];
  pl_t qc[$];
  int a_cnt = 0, a_gap_err = 0, a_last_cyc = -1;
  logic [7:0] a_lx;
  logic [6:0] a_ly;
  logic [2:0] a_lc;

  always @(negedge clk) begin
    if (ia.plot) begin
      if (a_cnt > 0 && cyc - a_last_cyc != 4) a_gap_err <= a_gap_err + 1;
      a_cnt      <= a_cnt + 1;
      a_last_cyc <= cyc;
      a_lx       <= ia.x_co;
      a_ly       <= ia.y_co;
      a_lc       <= ia.colour;
    end
    if (ib.plot) qb.push_back(pl_t'{cyc, ib.x_co, ib.y_co, ib.colour});
    if (ic.plot) qc.push_back(pl_t'{cyc, ic.x_co, ic.y_co, ic.colour});
  end

  task automatic wait_done_b(input int lim, input string tag);
    int n = 0;
    while (ib.out_cont_signal !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < lim), 1);
  endtask

  task automatic release_b(input string tag);
    ib.in_cont_signal = 1'b0;
    @(posedge clk); #1;
    ib.next_fin_signal = 1'b1;
    @(posedge clk); #1;
    ib.next_fin_signal = 1'b0;
    check({tag, "_rel_cont"}, ib.out_cont_signal, 0);
    check({tag, "_rel_busy"}, ib.busy, 0);
  endtask

  task automatic win_b(input int x0, input int y0, input int w, input int h);
    ib.win_x0 = 8'(x0);
    ib.win_y0 = 7'(y0);
    ib.win_w  = 9'(w);
    ib.win_h  = 8'(h);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 19200; i++) mem_b[i] = 3'(i);
    mem_b[4820] = 3'd0; mem_b[4821] = 3'd5; mem_b[4822] = 3'd0; mem_b[4823] = 3'd2;
    ia.in_cont_signal = 0; ia.next_fin_signal = 0; ia.bg_colour = 0;
    ia.win_x0 = 0; ia.win_y0 = 0; ia.win_w = 0; ia.win_h = 0;
    ib.in_cont_signal = 0; ib.next_fin_signal = 0; ib.bg_colour = 0;
    ib.win_x0 = 0; ib.win_y0 = 0; ib.win_w = 0; ib.win_h = 0;
    ic.in_cont_signal = 0; ic.next_fin_signal = 0; ic.bg_colour = 0;
    ic.win_x0 = 0; ic.win_y0 = 0; ic.win_w = 0; ic.win_h = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", ib.read_addr, 0);
    check("rst_x", ib.x_co, 0);
    check("rst_y", ib.y_co, 0);
    check("rst_col", ib.colour, 0);
    check("rst_plot", ib.plot, 0);
    check("rst_cont", ib.out_cont_signal, 0);
    check("rst_busy", ib.busy, 0);
    check("rst_busy_a", ia.busy, 0);
    rst_n = 1'b1;
    rst_b = 1'b1;

    fork
      begin : thread_a
        int n = 0;
        @(posedge clk); #1;
        ia.win_x0 = 0; ia.win_y0 = 0; ia.win_w = 160; ia.win_h = 120;
        ia.in_cont_signal = 1'b1;
        while (ia.out_cont_signal !== 1'b1 && n < 80000) begin
          @(negedge clk);
          n++;
        end
        check("full_timeout", 32'(n < 80000), 1);
        check("full_count", a_cnt, 19200);
        check("full_gap4", a_gap_err, 0);
        check("full_last_x", a_lx, 159);
        check("full_last_y", a_ly, 119);
        check("full_last_col", a_lc, 7);
        check("full_done_edge", cyc - a_last_cyc, 1);
        ia.in_cont_signal = 1'b0;
        @(posedge clk); #1;
        ia.next_fin_signal = 1'b1;
        @(posedge clk); #1;
        ia.next_fin_signal = 1'b0;
        check("full_release", ia.out_cont_signal, 0);
      end

      begin : thread_b
        int errs, k, n, t0;
        // clipped window
        qb.delete();
        @(posedge clk); #1;
        win_b(150, 115, 20, 10);
        ib.in_cont_signal = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("clip_first_addr", ib.read_addr, 18550);
        wait_done_b(1000, "clip");
        check("clip_count", qb.size(), 50);
        errs = 0; k = 0;
        for (int yy = 115; yy < 120; yy++)
          for (int xx = 150; xx < 160; xx++) begin
            if (k < qb.size())
              if (qb[k].x != 8'(xx) || qb[k].y != 7'(yy) || qb[k].c != 3'(yy*160 + xx)) errs++;
            k++;
          end
        check("clip_order", errs, 0);
        release_b("clip");

        // zero width
        qb.delete();
        @(posedge clk); #1;
        win_b(5, 5, 0, 3);
        ib.in_cont_signal = 1'b1;
        @(posedge clk); #1;
        check("empty_cont", ib.out_cont_signal, 1);
        check("empty_busy", ib.busy, 1);
        ib.in_cont_signal = 1'b0;
        ib.next_fin_signal = 1'b1;
        @(posedge clk); #1;
        ib.next_fin_signal = 1'b0;
        check("empty_rel_cont", ib.out_cont_signal, 0);
        check("empty_rel_busy", ib.busy, 0);
        check("empty_plots", qb.size(), 0);

        // x0 off-screen
        @(posedge clk); #1;
        win_b(160, 0, 4, 4);
        ib.in_cont_signal = 1'b1;
        @(posedge clk); #1;
        check("offscr_cont", ib.out_cont_signal, 1);
        release_b("offscr");
        check("offscr_plots", qb.size(), 0);

        // pause after 5th plot
        qb.delete();
        @(posedge clk); #1;
        win_b(0, 0, 4, 3);
        ib.in_cont_signal = 1'b1;
        n = 0;
        while (qb.size() < 5 && n < 500) begin
          @(posedge clk); #1;
          n++;
        end
        check("pause_reach5", 32'(n < 500), 1);
        ib.in_cont_signal = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("pause_noplot", qb.size(), 5);
        check("pause_busy", ib.busy, 1);
        ib.in_cont_signal = 1'b1;
        wait_done_b(500, "pause");
        check("pause_count", qb.size(), 12);
        errs = 0; k = 0;
        for (int yy = 0; yy < 3; yy++)
          for (int xx = 0; xx < 4; xx++) begin
            if (k < qb.size())
              if (qb[k].x != 8'(xx) || qb[k].y != 7'(yy) || qb[k].c != 3'(yy*160 + xx)) errs++;
            k++;
          end
        check("pause_order", errs, 0);
        if (qb.size() > 5) begin
          check("pause_6th_x", qb[5].x, 1);
          check("pause_6th_y", qb[5].y, 1);
          check("pause_6th_col", qb[5].c, 1);
        end
        release_b("pause");

        // background skip window (data 0,5,0,2)
        qb.delete();
        @(posedge clk); #1;
        win_b(20, 30, 4, 1);
        ib.bg_colour = 3'd0;
        ib.in_cont_signal = 1'b1;
        t0 = cyc;
        wait_done_b(200, "skip");
        check("skip_cycles", cyc - t0, 17);
`ifdef FLASH_SKIP_BG_EN
        check("skip_count", qb.size(), 2);
        if (qb.size() == 2) begin
          check("skip_p0_x", qb[0].x, 21);
          check("skip_p0_col", qb[0].c, 5);
          check("skip_p1_x", qb[1].x, 23);
          check("skip_p1_col", qb[1].c, 2);
        end
`else
        check("skip_count", qb.size(), 4);
        if (qb.size() == 4) begin
          check("skip_p0_col", qb[0].c, 0);
          check("skip_p1_col", qb[1].c, 5);
          check("skip_p2_col", qb[2].c, 0);
          check("skip_p3_x", qb[3].x, 23);
          check("skip_p3_col", qb[3].c, 2);
        end
`endif
        release_b("skip");

        // reset mid-frame
        qb.delete();
        @(posedge clk); #1;
        win_b(0, 0, 8, 8);
        ib.in_cont_signal = 1'b1;
        n = 0;
        while (qb.size() < 3 && n < 200) begin
          @(posedge clk); #1;
          n++;
        end
        check("mrst_reach3", 32'(n < 200), 1);
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk); #1;
        check("mrst_addr", ib.read_addr, 0);
        check("mrst_x", ib.x_co, 0);
        check("mrst_y", ib.y_co, 0);
        check("mrst_col", ib.colour, 0);
        check("mrst_plot", ib.plot, 0);
        check("mrst_cont", ib.out_cont_signal, 0);
        check("mrst_busy", ib.busy, 0);
        ib.in_cont_signal = 1'b0;
        rst_b = 1'b1;
      end

      begin : thread_c
        int n = 0;
        int ex[4] = '{10, 11, 10, 11};
        int ey[4] = '{10, 10, 11, 11};
        int ec[4] = '{6, 7, 4, 5};
        @(posedge clk); #1;
        ic.win_x0 = 10; ic.win_y0 = 10; ic.win_w = 2; ic.win_h = 2;
        ic.in_cont_signal = 1'b1;
        while (ic.out_cont_signal !== 1'b1 && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("lat3_timeout", 32'(n < 200), 1);
        check("lat3_count", qc.size(), 4);
        if (qc.size() == 4)
          for (int i = 0; i < 4; i++) begin
            check($sformatf("lat3_x%0d", i), qc[i].x, ex[i]);
            check($sformatf("lat3_y%0d", i), qc[i].y, ey[i]);
            check($sformatf("lat3_col%0d", i), qc[i].c, ec[i]);
            if (i > 0) check($sformatf("lat3_gap%0d", i), qc[i].t - qc[i-1].t, 6);
          end
        ic.in_cont_signal = 1'b0;
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
